// File: rtl/mem_pkg.sv
// Shared types for the load/store unit and its lane helper.
package mem_pkg;

   typedef enum logic [1:0] {
      SizeByte = 2'b00,
      SizeHalf = 2'b01,
      SizeWord = 2'b10
   } mem_size_e;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRmwRd,
      StWrite,
      StResp
   } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane helper: load extraction and extension, store merge, misalignment check.
module mem_lsu_align
   import mem_pkg::*;
#(
   parameter int unsigned XLen = 32
) (
   input  mem_size_e         chk_size,
   input  logic [1:0]        chk_off,
   output logic              misaligned,
   input  mem_size_e         size,
   input  logic [1:0]        off,
   input  logic              is_unsigned,
   input  logic [XLen-1:0]   rd_word,
   input  logic [XLen-1:0]   old_word,
   input  logic [XLen-1:0]   wdata,
   output logic [XLen-1:0]   load_data,
   output logic [XLen-1:0]   merge_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      misaligned = 1'b0;
      case (chk_size)
         SizeHalf: misaligned = chk_off[0];
         SizeWord: misaligned = (chk_off != 2'b00);
         default:  misaligned = 1'b0;
      endcase
   end

   always_comb begin
      byte_lane = rd_word[{off, 3'b000} +: 8];
      half_lane = off[1] ? rd_word[31:16] : rd_word[15:0];
      case (size)
         SizeByte: load_data = {{(XLen-8){~is_unsigned & byte_lane[7]}}, byte_lane};
         SizeHalf: load_data = {{(XLen-16){~is_unsigned & half_lane[15]}}, half_lane};
         default:  load_data = rd_word;
      endcase
   end

   // Sub-word stores overwrite only the addressed lane(s) of the previously read word.
   always_comb begin
      merge_data = old_word;
      case (size)
         SizeByte: merge_data[{off, 3'b000} +: 8] = wdata[7:0];
         SizeHalf: merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default:  merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a single-port word RAM; sub-word stores use read-modify-write.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int unsigned XLen = 32,
   parameter int unsigned NPos = 1024,
   localparam int unsigned NPosWidth = $clog2(NPos)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [XLen-1:0]      req_addr_i,
   input  logic [1:0]           req_size_i,
   input  logic                 req_unsigned_i,
   input  logic [XLen-1:0]      req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [XLen-1:0]      rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic [NPosWidth-1:0] ram_a_o,
   output logic [XLen-1:0]      ram_wd_o,
   output logic                 ram_we_o,
   input  logic [XLen-1:0]      ram_rd_i
);

   lsu_state_e           state_q, state_d;
   mem_size_e            size_q;
   logic [1:0]           off_q;
   logic                 uns_q;
   logic [NPosWidth-1:0] idx_q;
   logic [XLen-1:0]      wdata_q, old_q, rdata_q;
   logic                 err_q;

   mem_size_e       req_size;
   logic            misaligned, out_of_range, req_err, accept;
   logic [XLen-1:0] load_data, merge_data;

   assign req_size     = mem_size_e'(req_size_i);
   assign out_of_range = {2'b00, req_addr_i[XLen-1:2]} >= XLen'(NPos);
   assign req_err      = (req_size_i == 2'b11) | misaligned | out_of_range;
   assign accept       = (state_q == StIdle) & req_valid_i;

   mem_lsu_align #(
      .XLen (XLen)
   ) u_align (
      .chk_size    (req_size),
      .chk_off     (req_addr_i[1:0]),
      .misaligned  (misaligned),
      .size        (size_q),
      .off         (off_q),
      .is_unsigned (uns_q),
      .rd_word     (ram_rd_i),
      .old_word    (old_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merge_data  (merge_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         size_q  <= SizeByte;
         off_q   <= 2'b00;
         uns_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            size_q  <= req_size;
            off_q   <= req_addr_i[1:0];
            uns_q   <= req_unsigned_i;
            idx_q   <= req_addr_i[NPosWidth+1:2];
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
            err_q   <= req_err;
         end
         if (state_q == StLoad) rdata_q <= load_data;
         if (state_q == StRmwRd) old_q <= ram_rd_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      ram_we_o    = 1'b0;
      ram_wd_o    = '0;
      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (req_err)               state_d = StResp;
               else if (!req_we_i)        state_d = StLoad;
               else if (req_size == SizeWord) state_d = StWrite;
               else                       state_d = StRmwRd;
            end
         end
         StLoad:  state_d = StResp;
         StRmwRd: state_d = StWrite;
         StWrite: begin
            ram_we_o = 1'b1;
            ram_wd_o = merge_data;
            state_d  = StResp;
         end
         StResp: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ram_a_o     = idx_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a behavioural word RAM.
module tb_mem_lsu;

   localparam int unsigned XLen = 32;
   localparam int unsigned NPos = 1024;
   localparam int unsigned AW   = $clog2(NPos);

   logic            clk, rst_n;
   logic            req_valid, req_ready, req_we, req_unsigned;
   logic [XLen-1:0] req_addr, req_wdata;
   logic [1:0]      req_size;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [XLen-1:0] rsp_rdata;
   logic [AW-1:0]   ram_a;
   logic [XLen-1:0] ram_wd, ram_rd;
   logic            ram_we;

   logic [XLen-1:0] mem [NPos];
   int checks = 0;
   int errors = 0;
   int we_cnt;

   mem_lsu #(
      .XLen (XLen),
      .NPos (NPos)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_addr_i     (req_addr),
      .req_size_i     (req_size),
      .req_unsigned_i (req_unsigned),
      .req_wdata_i    (req_wdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_rdata_o    (rsp_rdata),
      .rsp_err_o      (rsp_err),
      .ram_a_o        (ram_a),
      .ram_wd_o       (ram_wd),
      .ram_we_o       (ram_we),
      .ram_rd_i       (ram_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_rd = mem[ram_a];
   always @(posedge clk) if (ram_we) mem[ram_a] = ram_wd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns #1 after the handshake edge, i.e. sampling cycle 1.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_err"},   32'(rsp_err), 32'd0);
      check({tag, "_a"},     32'(ram_a), 32'd0);
      check({tag, "_wd"},    ram_wd, 32'd0);
      check({tag, "_we"},    32'(ram_we), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < NPos; i++) mem[i] = '0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b00;
      req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk) rst_n = 1'b1;

      // Word store then word load.
      issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
      check("sw_we_c1", 32'(ram_we), 32'd1);
      check("sw_a_c1", 32'(ram_a), 32'd4);
      check("sw_wd_c1", ram_wd, 32'hDEADBEEF);
      check("sw_valid_c1", 32'(rsp_valid), 32'd0);
      step();
      check("sw_valid_c2", 32'(rsp_valid), 32'd1);
      check("sw_err_c2", 32'(rsp_err), 32'd0);
      check("sw_we_c2", 32'(ram_we), 32'd0);
      step();
      check("sw_mem", mem[4], 32'hDEADBEEF);
      issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      check("lw_ready_c1", 32'(req_ready), 32'd0);
      check("lw_valid_c1", 32'(rsp_valid), 32'd0);
      step();
      check("lw_valid_c2", 32'(rsp_valid), 32'd1);
      check("lw_rdata", rsp_rdata, 32'hDEADBEEF);
      check("lw_err", 32'(rsp_err), 32'd0);
      step();

      // Byte store read-modify-write.
      @(negedge clk) mem[4] = 32'h11223344;
      issue(1'b1, 32'h12, 2'b00, 1'b0, 32'h000000AA);
      we_cnt = int'(ram_we);
      check("sb_valid_c1", 32'(rsp_valid), 32'd0);
      step();
      we_cnt += int'(ram_we);
      check("sb_wd_c2", ram_wd, 32'h11AA3344);
      check("sb_valid_c2", 32'(rsp_valid), 32'd0);
      step();
      we_cnt += int'(ram_we);
      check("sb_valid_c3", 32'(rsp_valid), 32'd1);
      check("sb_we_once", 32'(we_cnt), 32'd1);
      step();
      check("sb_mem", mem[4], 32'h11AA3344);

      // Halfword store into the upper lane.
      issue(1'b1, 32'h12, 2'b01, 1'b0, 32'hCAFEBEEF);
      step(); step(); step();
      check("sh_mem", mem[4], 32'hBEEF3344);

      // Load lane extraction and extension.
      @(negedge clk) mem[4] = 32'h8081F0FF;
      issue(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
      step();
      check("lb_s_13", rsp_rdata, 32'hFFFFFF80);
      step();
      issue(1'b0, 32'h10, 2'b01, 1'b1, 32'h0);
      step();
      check("lhu_10", rsp_rdata, 32'h0000F0FF);
      step();
      issue(1'b0, 32'h12, 2'b01, 1'b0, 32'h0);
      step();
      check("lh_s_12", rsp_rdata, 32'hFFFF8081);
      step();
      issue(1'b0, 32'h11, 2'b00, 1'b1, 32'h0);
      step();
      check("lbu_11", rsp_rdata, 32'h000000F0);
      step();

      // Error requests respond at cycle 1 without touching RAM.
      issue(1'b0, 32'h11, 2'b01, 1'b0, 32'h0);
      check("err_h_valid", 32'(rsp_valid), 32'd1);
      check("err_h_err", 32'(rsp_err), 32'd1);
      check("err_h_rdata", rsp_rdata, 32'd0);
      check("err_h_we", 32'(ram_we), 32'd0);
      step();
      issue(1'b1, NPos * 4, 2'b10, 1'b0, 32'h12345678);
      check("err_oor_valid", 32'(rsp_valid), 32'd1);
      check("err_oor_err", 32'(rsp_err), 32'd1);
      check("err_oor_we", 32'(ram_we), 32'd0);
      step();
      check("err_oor_we_after", 32'(ram_we), 32'd0);
      issue(1'b1, 32'h10, 2'b11, 1'b0, 32'h12345678);
      check("err_rsv_err", 32'(rsp_err), 32'd1);
      step();
      check("err_rsv_mem", mem[4], 32'h8081F0FF);
      issue(1'b1, 32'h12, 2'b10, 1'b0, 32'h12345678);
      check("err_mw_err", 32'(rsp_err), 32'd1);
      step();

      // Response backpressure.
      rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rdata", rsp_rdata, 32'h8081F0FF);
         check("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      check("bp_idle_ready", 32'(req_ready), 32'd1);
      check("bp_idle_valid", 32'(rsp_valid), 32'd0);

      // Reset during RMW_RD aborts the store.
      @(negedge clk) mem[4] = 32'h11223344;
      issue(1'b1, 32'h10, 2'b00, 1'b0, 32'h00000055);
      check("rst_pre_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem", mem[4], 32'h11223344);
      check("rst_we", 32'(ram_we), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("rst_after_ready", 32'(req_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
